// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: writeback control bit
// positions, default datapath widths and the hard-wired zero register.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  // Bit positions inside the 2-bit WBControl bundle.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [DEF_REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: carries valid, load data, ALU result,
// destination register and writeback control with rst > flush > stall priority.
module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [REG_W-1:0]  i_wreg,
  input  logic [1:0]        i_ctrl,
  output logic              o_vld_p1,
  output logic [DATA_W-1:0] o_rdata_p1,
  output logic [DATA_W-1:0] o_alu_p1,
  output logic [REG_W-1:0]  o_wreg_p1,
  output logic [1:0]        o_ctrl_p1
);

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_rdata_p1;
  logic [DATA_W-1:0] r_alu_p1;
  logic [REG_W-1:0]  r_wreg_p1;
  logic [1:0]        r_ctrl_p1;

  // MEM -> WB boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_ctrl_p1  <= '0;
      r_rdata_p1 <= '0;
      r_alu_p1   <= '0;
      r_wreg_p1  <= '0;
    end else if (i_flush) begin
      // Bubble: data fields still load since a bubble never writes them back.
      r_vld_p1   <= 1'b0;
      r_ctrl_p1  <= '0;
      r_rdata_p1 <= i_rdata;
      r_alu_p1   <= i_alu;
      r_wreg_p1  <= i_wreg;
    end else if (!i_stall) begin
      r_vld_p1   <= i_valid;
      r_ctrl_p1  <= i_ctrl;
      r_rdata_p1 <= i_rdata;
      r_alu_p1   <= i_alu;
      r_wreg_p1  <= i_wreg;
    end
  end

  assign o_vld_p1   = r_vld_p1;
  assign o_rdata_p1 = r_rdata_p1;
  assign o_alu_p1   = r_alu_p1;
  assign o_wreg_p1  = r_wreg_p1;
  assign o_ctrl_p1  = r_ctrl_p1;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, writeback data select, $0 write
// suppression, forwarding export and retired-instruction counter.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic [1:0]        WBControl,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  output logic              RegWrite_out,
  output logic [REG_W-1:0]  WriteReg_wb,
  output logic [DATA_W-1:0] WriteData_wb,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired
);

  logic              w_vld_p1;
  logic [DATA_W-1:0] w_rdata_p1;
  logic [DATA_W-1:0] w_alu_p1;
  logic [REG_W-1:0]  w_wreg_p1;
  logic [1:0]        w_ctrl_p1;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [CNT_W-1:0]  r_retired;

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_mem_wb_reg (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (stall),
    .i_flush   (flush),
    .i_valid   (in_valid),
    .i_rdata   (ReadData),
    .i_alu     (ALUResult),
    .i_wreg    (WriteReg),
    .i_ctrl    (WBControl),
    .o_vld_p1  (w_vld_p1),
    .o_rdata_p1(w_rdata_p1),
    .o_alu_p1  (w_alu_p1),
    .o_wreg_p1 (w_wreg_p1),
    .o_ctrl_p1 (w_ctrl_p1)
  );

  assign w_wdata = w_ctrl_p1[WB_MEMTOREG] ? w_rdata_p1 : w_alu_p1;
  assign w_we    = w_vld_p1 && w_ctrl_p1[WB_REGWRITE]
                   && (w_wreg_p1 != REG_W'(ZERO_REG));

  // Counts at the edge an instruction leaves WB; a flush forces it out even under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_vld_p1 && (!stall || flush)) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign RegWrite_out = w_we;
  assign WriteReg_wb  = w_wreg_p1;
  assign WriteData_wb = w_wdata;
  assign fwd_valid    = w_we;
  assign fwd_reg      = w_wreg_p1;
  assign fwd_data     = w_wdata;
  assign retired      = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a random
// run against a cycle-level behavioural model of the MEM/WB slot.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ReadData;
  logic [31:0] ALUResult;
  logic [4:0]  WriteReg;
  logic [1:0]  WBControl;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic        RegWrite_out;
  logic [4:0]  WriteReg_wb;
  logic [31:0] WriteData_wb;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [31:0] retired;

  logic        s_we;
  logic [4:0]  s_wr;
  logic [31:0] s_wd;
  logic        s_fv;
  logic [4:0]  s_fr;
  logic [31:0] s_fd;
  logic [3:0]  s_retired;

  int n_checks = 0;
  int n_err    = 0;

  // Model of the instruction occupying WB
  logic        m_vld;
  logic [31:0] m_rd;
  logic [31:0] m_alu;
  logic [4:0]  m_wr;
  logic [1:0]  m_ctrl;
  logic        m_known;
  logic [31:0] m_ret;

  writeback_stage #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ReadData(ReadData), .ALUResult(ALUResult),
    .WriteReg(WriteReg), .WBControl(WBControl), .in_valid(in_valid),
    .stall(stall), .flush(flush), .RegWrite_out(RegWrite_out),
    .WriteReg_wb(WriteReg_wb), .WriteData_wb(WriteData_wb),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retired(retired)
  );

  writeback_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ReadData(ReadData), .ALUResult(ALUResult),
    .WriteReg(WriteReg), .WBControl(WBControl), .in_valid(in_valid),
    .stall(stall), .flush(flush), .RegWrite_out(s_we),
    .WriteReg_wb(s_wr), .WriteData_wb(s_wd),
    .fwd_valid(s_fv), .fwd_reg(s_fr), .fwd_data(s_fd),
    .retired(s_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got=running required=finished");
    $fatal(1);
  end

  function automatic logic exp_we();
    return m_vld && m_ctrl[1] && (m_wr != 5'd0);
  endfunction

  function automatic logic [31:0] exp_wd();
    return m_ctrl[0] ? m_rd : m_alu;
  endfunction

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic tick(input logic r, input logic f, input logic s, input logic v,
                      input logic [31:0] rd, input logic [31:0] alu,
                      input logic [4:0] wr, input logic [1:0] ctl);
    rst = r; flush = f; stall = s; in_valid = v;
    ReadData = rd; ALUResult = alu; WriteReg = wr; WBControl = ctl;
    @(posedge clk);
    if (r) begin
      m_vld = 0; m_rd = 0; m_alu = 0; m_wr = 0; m_ctrl = 0; m_known = 1; m_ret = 0;
    end else begin
      if (m_vld && (!s || f)) m_ret = m_ret + 1;
      if (f) begin
        m_vld = 0; m_ctrl = 0; m_known = 0;
      end else if (!s) begin
        m_vld = v; m_rd = rd; m_alu = alu; m_wr = wr; m_ctrl = ctl; m_known = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 2'b11);
    n_checks++; if (RegWrite_out !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b exp=0", RegWrite_out); end
    n_checks++; if (WriteReg_wb !== 5'd0) begin n_err++; $display("FAIL reset_wr got=%0d exp=0", WriteReg_wb); end
    n_checks++; if (WriteData_wb !== 32'd0) begin n_err++; $display("FAIL reset_wd got=%h exp=0", WriteData_wb); end
    n_checks++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv got=%0b exp=0", fwd_valid); end
    n_checks++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_ret got=%0d exp=0", retired); end
  endtask

  task automatic test_load_forward();
    tick(0, 0, 0, 1, 32'h12345678, 32'h00000004, 5'd2, 2'b11);
    n_checks++; if (RegWrite_out !== 1'b1) begin n_err++; $display("FAIL load_we got=%0b exp=1", RegWrite_out); end
    n_checks++; if (WriteReg_wb !== 5'd2) begin n_err++; $display("FAIL load_wr got=%0d exp=2", WriteReg_wb); end
    n_checks++; if (WriteData_wb !== 32'h12345678) begin n_err++; $display("FAIL load_wd got=%h exp=12345678", WriteData_wb); end
    n_checks++; if (fwd_data !== 32'h12345678) begin n_err++; $display("FAIL load_fd got=%h exp=12345678", fwd_data); end
    n_checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd2) begin n_err++; $display("FAIL load_fwd got=%0b/%0d exp=1/2", fwd_valid, fwd_reg); end
    n_checks++; if (retired !== 32'd0) begin n_err++; $display("FAIL load_ret got=%0d exp=0", retired); end
  endtask

  task automatic test_alu_forward();
    tick(0, 0, 0, 1, 32'h0BAD_F00D, 32'hDEADBEEF, 5'd7, 2'b10);
    n_checks++; if (RegWrite_out !== 1'b1) begin n_err++; $display("FAIL alu_we got=%0b exp=1", RegWrite_out); end
    n_checks++; if (WriteData_wb !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_wd got=%h exp=deadbeef", WriteData_wb); end
    n_checks++; if (WriteReg_wb !== 5'd7) begin n_err++; $display("FAIL alu_wr got=%0d exp=7", WriteReg_wb); end
    n_checks++; if (retired !== 32'd1) begin n_err++; $display("FAIL alu_ret got=%0d exp=1", retired); end
  endtask

  task automatic test_zero_and_store();
    tick(0, 0, 0, 1, 32'h1111_1111, 32'h2222_2222, 5'd0, 2'b10);
    n_checks++; if (RegWrite_out !== 1'b0) begin n_err++; $display("FAIL zero_we got=%0b exp=0", RegWrite_out); end
    n_checks++; if (WriteData_wb !== 32'h2222_2222) begin n_err++; $display("FAIL zero_wd got=%h exp=22222222", WriteData_wb); end
    n_checks++; if (retired !== 32'd2) begin n_err++; $display("FAIL zero_ret got=%0d exp=2", retired); end
    tick(0, 0, 0, 1, 32'h3333_3333, 32'h0000_0100, 5'd3, 2'b00);
    n_checks++; if (RegWrite_out !== 1'b0) begin n_err++; $display("FAIL store_we got=%0b exp=0", RegWrite_out); end
    n_checks++; if (WriteReg_wb !== 5'd3) begin n_err++; $display("FAIL store_wr got=%0d exp=3", WriteReg_wb); end
    n_checks++; if (retired !== 32'd3) begin n_err++; $display("FAIL store_ret got=%0d exp=3", retired); end
    tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    n_checks++; if (retired !== 32'd4) begin n_err++; $display("FAIL store_leave_ret got=%0d exp=4", retired); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] base;
    tick(0, 0, 0, 1, 32'h0, 32'h0000_0055, 5'd5, 2'b10);
    base = m_ret;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 1, $urandom, $urandom, 5'($urandom_range(1, 31)), 2'b11);
      n_checks++; if (RegWrite_out !== 1'b1 || WriteReg_wb !== 5'd5) begin n_err++; $display("FAIL stall_hold_%0d got=%0b/%0d exp=1/5", i, RegWrite_out, WriteReg_wb); end
      n_checks++; if (WriteData_wb !== 32'h55) begin n_err++; $display("FAIL stall_wd_%0d got=%h exp=55", i, WriteData_wb); end
      n_checks++; if (retired !== base) begin n_err++; $display("FAIL stall_ret_%0d got=%0d exp=%0d", i, retired, base); end
    end
    tick(0, 1, 1, 1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 5'd9, 2'b10);
    n_checks++; if (RegWrite_out !== 1'b0 || fwd_valid !== 1'b0) begin n_err++; $display("FAIL flush_we got=%0b/%0b exp=0/0", RegWrite_out, fwd_valid); end
    n_checks++; if (retired !== base + 1) begin n_err++; $display("FAIL flush_ret got=%0d exp=%0d", retired, base + 1); end
    tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    n_checks++; if (retired !== base + 1) begin n_err++; $display("FAIL bubble_ret got=%0d exp=%0d", retired, base + 1); end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 0, 1, 32'h5, 32'h6, 5'd12, 2'b11);
    tick(1, 1, 1, 1, 32'h7, 32'h8, 5'd13, 2'b11);
    n_checks++; if (RegWrite_out !== 1'b0 || WriteReg_wb !== 5'd0 || WriteData_wb !== 32'd0) begin n_err++; $display("FAIL rstmid_out got=%0b/%0d/%h exp=0/0/0", RegWrite_out, WriteReg_wb, WriteData_wb); end
    n_checks++; if (retired !== 32'd0) begin n_err++; $display("FAIL rstmid_ret got=%0d exp=0", retired); end
    tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    n_checks++; if (retired !== 32'd0) begin n_err++; $display("FAIL rstmid_after_ret got=%0d exp=0", retired); end
  endtask

  task automatic test_back_to_back_wrap();
    tick(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    for (int i = 0; i < 17; i++)
      tick(0, 0, 0, 1, $urandom, $urandom, 5'($urandom_range(0, 31)), 2'($urandom));
    tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    n_checks++; if (s_retired !== 4'd1) begin n_err++; $display("FAIL wrap_ret4 got=%0d exp=1", s_retired); end
    n_checks++; if (retired !== 32'd17) begin n_err++; $display("FAIL wrap_ret32 got=%0d exp=17", retired); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 80),
           $urandom, $urandom, 5'($urandom_range(0, 31)), 2'($urandom));
      n_checks++; if (RegWrite_out !== exp_we() || fwd_valid !== exp_we()) begin n_err++; $display("FAIL rand_we_%0d got=%0b/%0b exp=%0b", i, RegWrite_out, fwd_valid, exp_we()); end
      n_checks++; if (retired !== m_ret || s_retired !== m_ret[3:0]) begin n_err++; $display("FAIL rand_ret_%0d got=%0d/%0d exp=%0d", i, retired, s_retired, m_ret); end
      if (m_known) begin
        n_checks++; if (WriteReg_wb !== m_wr || fwd_reg !== m_wr) begin n_err++; $display("FAIL rand_wr_%0d got=%0d/%0d exp=%0d", i, WriteReg_wb, fwd_reg, m_wr); end
        n_checks++; if (WriteData_wb !== exp_wd() || fwd_data !== exp_wd()) begin n_err++; $display("FAIL rand_wd_%0d got=%h/%h exp=%h", i, WriteData_wb, fwd_data, exp_wd()); end
      end
    end
  endtask

  initial begin
    rst = 1; flush = 0; stall = 0; in_valid = 0;
    ReadData = 0; ALUResult = 0; WriteReg = 0; WBControl = 0;
    m_vld = 0; m_rd = 0; m_alu = 0; m_wr = 0; m_ctrl = 0; m_known = 0; m_ret = 0;
    test_reset();
    test_load_forward();
    test_alu_forward();
    test_zero_and_store();
    test_stall_flush();
    test_reset_mid();
    test_back_to_back_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
